// File: rtl/fifo_rd_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared constants and types for the sync_fifo read-side stream master.
//   WIDTH_DEF / CNT_W_DEF : default data width and delivered-word counter width
//   BUF_DEPTH             : entries in the output buffer that hides read latency
//   RD_LAT                : sync_fifo read latency in cycles (data follows r_en)
//   occ_t                 : output buffer occupancy (0..BUF_DEPTH)
// ----------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int BUF_DEPTH = 2;
    localparam int RD_LAT    = 1;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// ----------------------------------------------------------------------------
// stream_skid_buf
// Two-entry in-order buffer sitting between the FIFO read port and the
// downstream stream. Words enter at the tail and leave from the head.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_data into the tail slot this cycle
//   push_data  : word to write
//   pop        : retire the head word this cycle (only while occupancy != 0)
//   occupancy  : number of stored words (0..2)
//   head       : current head word; holds the last popped word while empty
// ----------------------------------------------------------------------------
module stream_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occupancy,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [0:1];
    logic             head_ptr;
    logic             tail_ptr;

    // Storage, pointers and occupancy. A simultaneous push and pop leaves the
    // occupancy unchanged while both pointers advance, so order is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            head_ptr  <= 1'b0;
            tail_ptr  <= 1'b0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[tail_ptr] <= push_data;
                tail_ptr      <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // When empty, the slot behind the head pointer still holds the word that
    // was popped last (a push into an empty buffer lands on the head slot),
    // so presenting it keeps out_data steady without an extra register.
    assign head = (occupancy == '0) ? mem[~head_ptr] : mem[head_ptr];

    // The issue logic upstream guarantees room for every word in flight.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occupancy == 2'd2));

    assert property (@(posedge clk) disable iff (rst)
        !(pop && occupancy == 2'd0));

endmodule

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side master for sync_fifo: issues r_en reads, captures the data one
// cycle later into a 2-entry buffer and presents it as a valid/ready stream.
// Sustains one word per clock under continuous out_ready.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   en         : allow new FIFO reads
//   empty      : FIFO empty flag
//   r_en       : FIFO read enable (combinational, forced low during reset)
//   fifo_data  : FIFO data_out, valid the cycle after an accepted r_en
//   out_valid  : stream word valid
//   out_ready  : downstream accepts the word
//   out_data   : stream word
//   rd_count   : number of delivered words, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    output logic             r_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] rd_count
);

    occ_t       occupancy;
    logic       inflight;
    logic       pop;
    logic       issue;
    logic [2:0] committed;

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;

    // Slots already promised after this cycle's pop: buffered words plus the
    // word arriving from the FIFO. Counting the pop lets a new read go out in
    // the same cycle a word leaves, which is what gives full throughput; it
    // makes out_ready -> r_en a deliberate combinational path.
    assign committed = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = en && !empty && (committed < 3'(BUF_DEPTH));
    assign r_en      = issue && !rst;

    // A read accepted at one edge returns its word for capture at the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_en;
        end
    end

    // Delivered-word counter, wrapping naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + CNT_W'(1);
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .occupancy (occupancy),
        .head      (out_data)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Drives fifo_stream_reader from a behavioural sync_fifo (a queue with one
// cycle of read latency) and checks the delivered stream against the words
// loaded into the FIFO, plus counter, timing and stall-stability rules.
// The counter width is reduced to 4 bits so wrap-around is reachable.
// ----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          empty = 1'b1;
    logic          r_en;
    logic [W-1:0]  fifo_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] rd_count;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO contents and the expected delivery order.
    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];

    // Abstract model state: words delivered, reads issued, words owed.
    int           model_count;
    int           r_en_pulses;
    int           outstanding;
    bit           last_issued;
    bit           prev_stall;
    logic [W-1:0] prev_data;

    // Last sampled outputs, for directed checks by the caller.
    logic         s_r_en;
    logic         s_valid;
    logic [W-1:0] s_data;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .empty     (empty),
        .r_en      (r_en),
        .fifo_data (fifo_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rd_count  (rd_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit r);
        en        = e;
        out_ready = r;
    endtask

    task automatic preload(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    // Asserts reset (asynchronously, from wherever we are), checks the
    // immediate effect, empties the FIFO model and releases after two edges.
    task automatic applyReset();
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        empty     = 1'b1;
        fifo_data = '0;
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_rd_count", rd_count, 0);
        checkOutput("reset_r_en", r_en, 0);
        model_count = 0;
        r_en_pulses = 0;
        outstanding = 0;
        last_issued = 0;
        prev_stall  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_hold_r_en", r_en, 0);
        rst = 1'b0;
    endtask

    // One clock: sample and check at the falling edge, then model the FIFO
    // read at the rising edge and check the counter just after it.
    task automatic runCycle();
        bit issued;
        bit pop_now;
        @(negedge clk);
        s_r_en  = r_en;
        s_valid = out_valid;
        s_data  = out_data;
        pop_now = out_valid && out_ready;

        checkOutput("outstanding_le_2", 32'(outstanding <= 2), 1);
        checkOutput("valid_rule", out_valid, 32'((outstanding - int'(last_issued)) > 0));
        checkOutput("r_en_rule", r_en,
                    32'(en && !empty && ((outstanding - int'(pop_now)) < 2)));
        if (prev_stall) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data", out_data, 32'(prev_data));
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;

        issued = r_en;
        if (r_en) begin
            r_en_pulses++;
            outstanding++;
        end
        if (pop_now) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL spurious_word: observed=0x%0h expected=none", out_data);
            end else begin
                checkOutput("word_order", out_data, 32'(exp_q.pop_front()));
            end
            model_count++;
            outstanding--;
        end
        last_issued = issued;

        @(posedge clk);
        #1;
        if (issued && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
        checkOutput("rd_count", rd_count, 32'(model_count % 16));
    endtask

    task automatic drainAll(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding != 0) && n < budget) begin
            runCycle();
            n++;
        end
        checkOutput({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        #2;
        applyReset();

        // Continuous streaming: 2-cycle fill, then 8 back-to-back words.
        for (int i = 0; i < 8; i++) preload(W'(8'h11 + i));
        applyStimulus(1, 1);
        runCycle();
        checkOutput("t1_first_r_en", s_r_en, 1);
        checkOutput("t1_c0_valid", s_valid, 0);
        runCycle();
        checkOutput("t1_c1_valid", s_valid, 0);
        for (int i = 0; i < 8; i++) begin
            runCycle();
            checkOutput("t1_stream_valid", s_valid, 1);
            checkOutput("t1_stream_data", s_data, 32'(8'h11 + i));
        end
        for (int i = 0; i < 3; i++) begin
            runCycle();
            checkOutput("t1_idle_r_en", s_r_en, 0);
            checkOutput("t1_idle_valid", s_valid, 0);
        end
        checkOutput("t1_rd_count", rd_count, 8);

        // Downstream stalled: two reads fill the buffer, head held steady.
        applyReset();
        for (int i = 0; i < 8; i++) preload(W'(8'h11 + i));
        applyStimulus(1, 0);
        repeat (6) runCycle();
        checkOutput("t2_r_en_pulses", r_en_pulses, 2);
        checkOutput("t2_valid", s_valid, 1);
        checkOutput("t2_head", s_data, 32'h11);
        applyStimulus(1, 1);
        for (int i = 0; i < 8; i++) begin
            runCycle();
            checkOutput("t2_no_gap_valid", s_valid, 1);
            checkOutput("t2_data", s_data, 32'(8'h11 + i));
        end
        drainAll("t2", 20);
        checkOutput("t2_rd_count", rd_count, 8);

        // Alternating out_ready.
        applyReset();
        for (int i = 0; i < 8; i++) preload(W'(8'h11 + i));
        n = 0;
        while (model_count < 8 && n < 40) begin
            applyStimulus(1, (n % 2) == 0);
            runCycle();
            n++;
        end
        checkOutput("t3_rd_count", rd_count, 8);
        checkOutput("t3_all_seen", exp_q.size(), 0);

        // Drop en after three reads.
        applyReset();
        for (int i = 0; i < 8; i++) preload(W'(8'h11 + i));
        applyStimulus(1, 1);
        n = 0;
        while (r_en_pulses < 3 && n < 20) begin
            runCycle();
            n++;
        end
        applyStimulus(0, 1);
        repeat (6) runCycle();
        checkOutput("t4_r_en_pulses", r_en_pulses, 3);
        checkOutput("t4_rd_count", rd_count, 3);
        checkOutput("t4_idle_valid", s_valid, 0);
        applyStimulus(1, 1);
        n = 0;
        s_valid = 1'b0;
        while (!s_valid && n < 10) begin
            runCycle();
            n++;
        end
        checkOutput("t4_resume_data", s_data, 32'h14);
        drainAll("t4", 20);

        // Reset in the middle of a stream, then a fresh burst.
        applyReset();
        for (int i = 0; i < 8; i++) preload(W'(8'h11 + i));
        applyStimulus(1, 1);
        n = 0;
        while (model_count < 4 && n < 20) begin
            runCycle();
            n++;
        end
        checkOutput("t5_valid_before_reset", out_valid, 1);
        applyReset();
        for (int i = 0; i < 4; i++) preload(W'(8'hA0 + i));
        applyStimulus(1, 1);
        drainAll("t5", 20);
        checkOutput("t5_rd_count", rd_count, 4);

        // Counter wrap with a 4-bit counter: 20 words leave it at 4.
        applyReset();
        for (int i = 0; i < 20; i++) preload(W'(8'h30 + i));
        applyStimulus(1, 1);
        drainAll("t6", 60);
        checkOutput("t6_wrap", rd_count, 4);

        // Random en, out_ready and FIFO refills (empty toggles mid-stream).
        applyReset();
        for (int c = 0; c < 200; c++) begin
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) preload(W'($urandom));
            runCycle();
        end
        applyStimulus(1, 1);
        drainAll("t7", 150);
        checkOutput("t7_rd_count", rd_count, 32'(model_count % 16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
